// File: rtl/cic_decimator_nstage.sv
// Generalised N-stage CIC decimator: integrators at the input rate, runtime-programmable
// decimation, pipelined combs, output priming and a valid/ready port with sticky overrun.
module cic_decimator_nstage #(
  parameter int unsigned IN_WIDTH = 2,
  parameter int unsigned ORDER    = 2,
  parameter int unsigned RMAX     = 256,
  parameter int unsigned RW       = $clog2(RMAX) + 1,
  parameter int unsigned AW       = IN_WIDTH + ORDER * $clog2(RMAX)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       en,
  input  logic signed [IN_WIDTH-1:0] din,
  input  logic        [RW-1:0]       ratio,
  output logic signed [AW-1:0]       dout,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic                       overrun,
  output logic                       primed
);
  localparam int unsigned CW = $clog2(RMAX);
  localparam int unsigned PW = $clog2(ORDER + 1);

  typedef enum logic [0:0] {StPrime, StRun} state_e;

  logic signed [AW-1:0] din_ext;
  logic        [RW-1:0] ratio_clamped;
  logic signed [AW-1:0] integ_q [ORDER];
  logic        [CW-1:0] cnt_q;
  logic        [RW-1:0] ratio_q;
  logic                 wrap;
  logic                 dec_stb_q;
  logic                 dec_tag_q;
  logic signed [AW-1:0] comb_x     [ORDER];
  logic signed [AW-1:0] comb_y_q   [ORDER];
  logic signed [AW-1:0] comb_dly_q [ORDER];
  logic     [ORDER-1:0] comb_stb_in, comb_tag_in, comb_stb_q, comb_tag_q;
  state_e               state_q, state_d;
  logic        [PW-1:0] prime_cnt_q, prime_cnt_d;
  logic signed [AW-1:0] dout_q, dout_d;
  logic                 valid_q, valid_d, overrun_q, overrun_d;

  assign din_ext = {{(AW - IN_WIDTH){din[IN_WIDTH-1]}}, din};

  always_comb begin
    ratio_clamped = ratio;
    if (ratio < RW'(2)) begin
      ratio_clamped = RW'(2);
    end else if (ratio > RW'(RMAX)) begin
      ratio_clamped = RW'(RMAX);
    end
  end

  assign wrap = en && ({1'b0, cnt_q} == (ratio_q - RW'(1)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int unsigned i = 0; i < ORDER; i++) integ_q[i] <= '0;
    end else if (en) begin
      integ_q[0] <= integ_q[0] + din_ext;
      for (int unsigned i = 1; i < ORDER; i++) integ_q[i] <= integ_q[i] + integ_q[i-1];
    end
  end

  // The tag marks the last block at the old ratio; priming restarts once its result emerges.
  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt_q     <= '0;
      ratio_q   <= ratio_clamped;
      dec_stb_q <= 1'b0;
      dec_tag_q <= 1'b0;
    end else begin
      dec_stb_q <= wrap;
      dec_tag_q <= wrap && (ratio_clamped != ratio_q);
      if (wrap) begin
        cnt_q   <= '0;
        ratio_q <= ratio_clamped;
      end else if (en) begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  always_comb begin
    comb_x[0]      = integ_q[ORDER-1];
    comb_stb_in[0] = dec_stb_q;
    comb_tag_in[0] = dec_tag_q;
    for (int unsigned i = 1; i < ORDER; i++) begin
      comb_x[i]      = comb_y_q[i-1];
      comb_stb_in[i] = comb_stb_q[i-1];
      comb_tag_in[i] = comb_tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      comb_stb_q <= '0;
      comb_tag_q <= '0;
      for (int unsigned i = 0; i < ORDER; i++) begin
        comb_y_q[i]   <= '0;
        comb_dly_q[i] <= '0;
      end
    end else begin
      comb_stb_q <= comb_stb_in;
      comb_tag_q <= comb_tag_in;
      for (int unsigned i = 0; i < ORDER; i++) begin
        if (comb_stb_in[i]) begin
          comb_y_q[i]   <= comb_x[i] - comb_dly_q[i];
          comb_dly_q[i] <= comb_x[i];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    prime_cnt_d = prime_cnt_q;
    dout_d      = dout_q;
    valid_d     = valid_q && !dout_ready;
    overrun_d   = overrun_q;
    if (comb_stb_q[ORDER-1]) begin
      if (state_q == StRun) begin
        if (!valid_q || dout_ready) begin
          dout_d  = comb_y_q[ORDER-1];
          valid_d = 1'b1;
        end else begin
          overrun_d = 1'b1;
        end
      end else if (prime_cnt_q == PW'(ORDER - 1)) begin
        state_d     = StRun;
        prime_cnt_d = '0;
      end else begin
        prime_cnt_d = prime_cnt_q + PW'(1);
      end
      if (comb_tag_q[ORDER-1]) begin
        state_d     = StPrime;
        prime_cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StPrime;
      prime_cnt_q <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      prime_cnt_q <= prime_cnt_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      overrun_q   <= overrun_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = valid_q;
  assign overrun    = overrun_q;
  assign primed     = (state_q == StRun);

endmodule

// File: tb/tb_cic_decimator_nstage.sv
// Bench for cic_decimator_nstage: ORDER=2 and ORDER=3 instances share stimulus and are checked
// against a sample-domain closed-form CIC model with a latency/priming/handshake scoreboard.
module tb_cic_decimator_nstage;
  localparam int RMAX = 256;
  localparam int RW   = 9;
  localparam int AW2  = 18;
  localparam int AW3  = 26;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                  reset, en, dout_ready;
  logic signed [1:0]     din;
  logic        [RW-1:0]  ratio;
  logic signed [AW2-1:0] dout2;
  logic signed [AW3-1:0] dout3;
  logic                  v2, v3, ovr2, ovr3, pr2, pr3;

  cic_decimator_nstage #(.IN_WIDTH(2), .ORDER(2), .RMAX(RMAX)) u_dut2 (
    .clk(clk), .reset(reset), .en(en), .din(din), .ratio(ratio), .dout(dout2),
    .dout_valid(v2), .dout_ready(dout_ready), .overrun(ovr2), .primed(pr2)
  );

  cic_decimator_nstage #(.IN_WIDTH(2), .ORDER(3), .RMAX(RMAX)) u_dut3 (
    .clk(clk), .reset(reset), .en(en), .din(din), .ratio(ratio), .dout(dout3),
    .dout_valid(v3), .dout_ready(dout_ready), .overrun(ovr3), .primed(pr3)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tg, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tg, $time, got, exp);
    end
  endtask

  // Reference model: one block event per decimation, each instance consumes it ORDER+1 edges later.
  typedef struct {
    longint t;
    longint v0;
    longint v1;
    bit     tag;
  } ev_t;

  int     smp[$];
  ev_t    ev[$];
  int     rd[2];
  int     ordv[2] = '{2, 3};
  int     cnt, r_lat;
  longint cyc = 0;
  longint hist[2][6];
  bit     mvalid[2], movr[2], mprime[2];
  longint mdout[2];
  int     mpcnt[2];

  function automatic longint binom(longint n, int k);
    longint r = 1;
    if (n < k) return 0;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // Last integrator after n samples: sum of x[j] * C(n-1-j, ORDER-1).
  function automatic longint ival(int ord);
    longint s = 0;
    int n = smp.size();
    for (int j = 0; j < n; j++) s += longint'(smp[j]) * binom(longint'(n - 1 - j), ord - 1);
    return s;
  endfunction

  function automatic int clampr(int r);
    if (r < 2) return 2;
    if (r > RMAX) return RMAX;
    return r;
  endfunction

  function automatic longint sx(longint v, int w);
    return (v <<< (64 - w)) >>> (64 - w);
  endfunction

  task automatic model_edge();
    bit     nv;
    ev_t    e;
    longint d, y, val;
    int     nr;
    if (!reset) begin
      smp.delete();
      ev.delete();
      cnt   = 0;
      r_lat = clampr(int'(ratio));
      for (int o = 0; o < 2; o++) begin
        rd[o] = 0; mvalid[o] = 0; mdout[o] = 0; movr[o] = 0; mprime[o] = 1; mpcnt[o] = 0;
        for (int m = 0; m < 6; m++) hist[o][m] = 0;
      end
    end else begin
      for (int o = 0; o < 2; o++) begin
        nv = mvalid[o] && !dout_ready;
        if (rd[o] < ev.size() && ev[rd[o]].t + ordv[o] + 1 == cyc) begin
          val = (o == 0) ? ev[rd[o]].v0 : ev[rd[o]].v1;
          if (!mprime[o]) begin
            if (!mvalid[o] || dout_ready) begin
              mdout[o] = val;
              nv = 1;
            end else begin
              movr[o] = 1;
            end
          end else begin
            mpcnt[o]++;
            if (mpcnt[o] == ordv[o]) begin
              mprime[o] = 0;
              mpcnt[o]  = 0;
            end
          end
          if (ev[rd[o]].tag) begin
            mprime[o] = 1;
            mpcnt[o]  = 0;
          end
          rd[o]++;
        end
        mvalid[o] = nv;
      end
      if (en) begin
        smp.push_back(int'(din));
        cnt++;
        if (cnt == r_lat) begin
          nr    = clampr(int'(ratio));
          e.t   = cyc;
          e.tag = (nr != r_lat);
          r_lat = nr;
          cnt   = 0;
          for (int o = 0; o < 2; o++) begin
            d = ival(ordv[o]);
            for (int m = 5; m > 0; m--) hist[o][m] = hist[o][m-1];
            hist[o][0] = d;
            y = 0;
            for (int m = 0; m <= ordv[o]; m++) begin
              if (m % 2 == 1) y -= binom(longint'(ordv[o]), m) * hist[o][m];
              else            y += binom(longint'(ordv[o]), m) * hist[o][m];
            end
            if (o == 0) e.v0 = y;
            else        e.v1 = y;
          end
          ev.push_back(e);
        end
      end
    end
    cyc++;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("valid2", v2, mvalid[0]);
    check("primed2", pr2, !mprime[0]);
    check("overrun2", ovr2, movr[0]);
    check("dout2", dout2, sx(mdout[0], AW2));
    check("valid3", v3, mvalid[1]);
    check("primed3", pr3, !mprime[1]);
    check("overrun3", ovr3, movr[1]);
    check("dout3", dout3, sx(mdout[1], AW3));
  endtask

  task automatic do_reset(input int r);
    ratio = RW'(r);
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic run_prime(input string tg);
    bit seen = 0;
    int pulses = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!seen && v2) begin
        seen = 1;
        check({tg, "_lat"}, longint'(smp.size()), 15);
        check({tg, "_first"}, dout2, 16);
      end
    end
    if (!seen) check({tg, "_timeout"}, 0, 1);
    for (int i = 0; i < 40; i++) begin
      tick();
      if (v2) pulses++;
    end
    check({tg, "_pulses"}, pulses, 10);
    check({tg, "_steady"}, dout2, 16);
  endtask

  initial begin
    int     pulses;
    int     seen;
    bit     saw_unprimed;
    longint pres[$];
    reset = 1'b0; en = 1'b0; din = '0; ratio = RW'(4); dout_ready = 1'b1;

    // Reset state, then priming with continuous input.
    do_reset(4);
    check("rst_valid", v2, 0);
    check("rst_primed", pr2, 0);
    check("rst_dout", dout2, 0);
    din = 2'sd1; en = 1'b1;
    run_prime("prime");

    // Gapped input stretches the period to 8 cycles.
    do_reset(4);
    pulses = 0;
    for (int i = 0; i < 160; i++) begin
      en = (i % 2 == 0);
      tick();
      if (i >= 80 && v2) pulses++;
    end
    check("gap_pulses", pulses, 10);
    check("gap_steady", dout2, 16);

    // R=256 extremes for both orders.
    en = 1'b1; din = 2'sd1;
    do_reset(256);
    for (int i = 0; i < 256 * 5 + 10; i++) tick();
    check("r256_pos3", dout3, 16777216);
    check("r256_pos2", dout2, 65536);
    din = -2'sd2;
    for (int i = 0; i < 256 * 5 + 10; i++) tick();
    check("r256_neg3", dout3, -33554432);
    check("r256_neg2", dout2, -131072);

    // Ratio change 4 -> 8 mid-block.
    din = 2'sd1;
    do_reset(4);
    for (int i = 0; i < 42; i++) tick();
    ratio = RW'(8);
    saw_unprimed = 0;
    pres.delete();
    for (int i = 0; i < 120; i++) begin
      tick();
      if (!pr2) saw_unprimed = 1;
      if (v2) pres.push_back(longint'(dout2));
    end
    check("rchg_unprimed", saw_unprimed, 1);
    check("rchg_count", longint'(pres.size() > 3), 1);
    if (pres.size() > 0) begin
      check("rchg_first", pres[0], 16);
      check("rchg_last", pres[pres.size() - 1], 64);
      foreach (pres[k]) check("rchg_set", longint'(pres[k] == 16 || pres[k] == 64), 1);
    end

    // Clamping of out-of-range ratios.
    do_reset(1);
    for (int i = 0; i < 40; i++) tick();
    check("clamp_lo2", dout2, 4);
    check("clamp_lo3", dout3, 8);
    do_reset(511);
    for (int i = 0; i < 256 * 4 + 10; i++) tick();
    check("clamp_hi2", dout2, 65536);

    // Backpressure across two results.
    do_reset(4);
    for (int i = 0; i < 40; i++) tick();
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (v2) seen = 1;
    end
    check("bp_seen", seen, 1);
    dout_ready = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("bp_hold_valid", v2, 1);
    check("bp_hold_dout", dout2, 16);
    check("bp_overrun", ovr2, 1);
    dout_ready = 1'b1;
    for (int i = 0; i < 20; i++) tick();
    check("bp_sticky", ovr2, 1);

    // Reset mid-block discards everything, then priming repeats.
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("mrst_valid", v2, 0);
    check("mrst_overrun", ovr2, 0);
    check("mrst_primed", pr2, 0);
    check("mrst_dout", dout2, 0);
    reset = 1'b1;
    run_prime("reprime");

    // Randomised traffic.
    do_reset(int'($urandom_range(0, 10)));
    for (int i = 0; i < 3000; i++) begin
      en         = ($urandom_range(0, 4) != 0);
      din        = 2'($urandom_range(0, 3));
      dout_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 199) == 0) ratio = RW'($urandom_range(0, 12));
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cic_decimator_nstage.md
Name: cic_decimator_nstage

Overview:
- Generalised N-stage CIC decimator: ORDER cascaded integrators at the input rate, a decimator with a runtime-programmable ratio, then ORDER pipelined comb stages.
- Sits directly behind the delta-sigma modulator bitstream and ahead of the compensation/averaging FIR.
- Adds what the fixed 2-stage chain lacks: any order, multi-bit signed input, sample-enable gating, runtime ratio with output priming, and a valid/ready output with overrun detection.

Parameters:
- IN_WIDTH, 2: signed two's-complement input width. A 1-bit modulator maps to 0/+1 or -1/+1 upstream.
- ORDER, 2: number of integrator stages and number of comb stages, legal range 1..5.
- RMAX, 256: maximum decimation ratio, power of two, at least 2.
- RW, clog2(RMAX)+1: width of the ratio port.
- AW, IN_WIDTH+ORDER*clog2(RMAX): internal and output word width (full CIC bit growth).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-low reset.
- en  in  1  input sample strobe; din is consumed only when en=1.
- din  in  IN_WIDTH  signed input sample.
- ratio  in  RW  decimation ratio R. Values below 2 clamp to 2; values above RMAX clamp to RMAX.
- dout  out  AW  signed decimated output.
- dout_valid  out  1  output holds a valid word.
- dout_ready  in  1  downstream accepts dout this cycle.
- overrun  out  1  sticky; set when a comb result is dropped.
- primed  out  1  high when state=RUN.

Behaviour:
- Reset (reset=0 at an edge):
  - All integrator, comb-delay and pipeline registers go to 0.
  - Decimation counter goes to 0; the ratio is latched from the port, clamped.
  - State goes to PRIME with prime_cnt=0.
  - dout=0, dout_valid=0, overrun=0, primed=0.
  - Reset asserted mid-block or mid-pipeline discards everything in flight.
- Arithmetic:
  - din is sign-extended to AW.
  - All adds and subtracts are modulo 2^AW; wrap is permitted and no saturation is applied.
- Integrators:
  - On an edge with en=1, stage 1 += din and stage i += stage i-1 (the registered value before this edge).
  - With en=0 every integrator holds its value.
- Decimation:
  - The counter increments on each en=1 cycle.
  - On an en=1 edge with count==R_latched-1: the counter wraps to 0 and a decimation strobe is registered at the next edge, capturing the last integrator.
  - R_latched reloads from the clamped ratio port on that same wrap edge. A ratio change mid-block therefore takes effect only at the next block.
- Comb pipeline:
  - Each stage computes y=x-delay, then delay<=x, only on its strobe. Each stage adds one register.
  - dout candidate appears ORDER+1 edges after the edge accepting the R-th sample of a block.
  - The pipeline never stalls.
- State machine:
  - PRIME: comb results are discarded; prime_cnt increments per result. After ORDER discarded results, go to RUN.
  - RUN: comb results are presented at the output.
  - RUN to PRIME (prime_cnt=0) whenever R_latched reloads with a value different from the previous one. Equal reloads keep RUN.
- Output handshake:
  - A word transfers on an edge with dout_valid=1 and dout_ready=1.
  - A new result is loaded when dout_valid=0, or when it coincides with a transfer. dout_valid then stays 1 with the new dout.
  - When dout_valid=1 and dout_ready=0, dout and dout_valid hold.
  - A result arriving while holding is dropped and overrun is set. overrun clears only on reset.
  - With dout_valid=0, dout keeps its last value.

Test Plan:
- ORDER=2, IN_WIDTH=2, R=4, din=+1 continuous, en=1, dout_ready=1:
  - The first 2 comb results are suppressed (dout_valid stays 0, primed=0).
  - Then primed=1 and every output is 16, one dout_valid pulse per 4 cycles.
  - The first valid output arrives 3 edges after the 12th accepted sample.
- Same setup with en toggling 1,0,1,0 (gaps inserted):
  - Output sequence is identical (16s).
  - The period stretches to 8 cycles.
- ORDER=3, RMAX=256, IN_WIDTH=2, R=256:
  - din=+1 gives steady dout=16777216.
  - din=-2 gives steady dout=-33554432 (AW=26 extreme, no wrap error).
- ORDER=2, din=+1, R changed 4 to 8 mid-block:
  - The current block completes with R=4 and outputs 16.
  - The next 2 results are suppressed (primed=0).
  - Then steady 64.
  - ratio=1 behaves as R=2; ratio=0x1FF with RMAX=256 behaves as 256.
- Backpressure, ORDER=2, R=4, din=+1, in RUN: hold dout_ready=0 across two results.
  - The first word (16) holds with dout_valid=1.
  - The second is dropped and overrun=1.
  - After dout_ready=1, the 16 transfers and the next result follows. overrun stays 1.
- Reset asserted low for 1 cycle mid-block:
  - Next cycle: dout=0, dout_valid=0, overrun=0, primed=0.
  - Priming repeats exactly as in the first scenario.
